// File: rtl/sm_bin_to_bcd.sv
// sm_bin_to_bcd
// Sequential binary-to-BCD converter feeding the 8-digit seven-segment driver.
// A 32-bit unsigned value is turned into 8 packed BCD digits with iterative
// double-dabble, one shift per clock, plus a leading-zero blanking mask.
//
// Ports:
//   clock     in   1   system clock, rising edge
//   reset     in   1   asynchronous active-high reset
//   start     in   1   conversion request, sampled only while idle
//   bin       in  32   unsigned binary value, sampled on the accepting edge
//   busy      out  1   high while a conversion is in progress
//   done      out  1   one-cycle pulse when bcd/digit_on/overflow update
//   bcd       out 32   packed BCD, digit k at bcd[4k+3:4k]
//   digit_on  out  8   bit k set when digit k should be lit
//   overflow  out  1   last converted value exceeded 99,999,999
module sm_bin_to_bcd (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] bin,
    output logic        busy,
    output logic        done,
    output logic [31:0] bcd,
    output logic [7:0]  digit_on,
    output logic        overflow
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state_q;
    logic [26:0] shiftReg_q;
    logic [26:0] shiftReg_d;
    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic [31:0] accAdj;
    logic [4:0]  count_q;
    logic        ovf_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] bcd_q;
    logic [7:0]  digitOn_q;
    logic [7:0]  digitOn_d;
    logic        overflow_q;
    logic        leadOn;

    // One double-dabble step: correct every digit that would exceed 9 after
    // doubling, then shift the next binary bit in at the bottom. Digits are at
    // most 9 before correction, so the 4-bit add never carries across digits.
    // The blanking mask is derived from the post-shift value so it is ready on
    // the same edge that registers the final result.
    always_comb begin
        accAdj = acc_q;
        for (int k = 0; k < 8; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                accAdj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
        acc_d      = {accAdj[30:0], shiftReg_q[26]};
        shiftReg_d = {shiftReg_q[25:0], 1'b0};

        // Scanning from the most significant digit down, a digit is lit once
        // any digit at or above it is nonzero. Digit 0 always shows.
        leadOn    = 1'b0;
        digitOn_d = 8'h00;
        for (int k = 7; k >= 0; k--) begin
            leadOn       = leadOn | (acc_d[4*k +: 4] != 4'd0);
            digitOn_d[k] = leadOn;
        end
        digitOn_d[0] = 1'b1;
    end

    // Control FSM with all outputs registered. Only the low 27 bits of bin are
    // shifted since 99,999,999 fits in 27 bits; anything larger is flagged by
    // the compare and replaced by all nines on completion.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= 32'h0;
            digitOn_q  <= 8'b0000_0001;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shiftReg_q <= bin[26:0];
                        acc_q      <= '0;
                        ovf_q      <= (bin > 32'd99_999_999);
                        count_q    <= 5'd27;
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc_q      <= acc_d;
                    shiftReg_q <= shiftReg_d;
                    count_q    <= count_q - 5'd1;
                    if (count_q == 5'd1) begin
                        bcd_q      <= ovf_q ? 32'h9999_9999 : acc_d;
                        digitOn_q  <= ovf_q ? 8'hFF : digitOn_d;
                        overflow_q <= ovf_q;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign digit_on = digitOn_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_sm_bin_to_bcd.sv
// tb_sm_bin_to_bcd
// Self-checking bench for sm_bin_to_bcd. Expected results come from a decimal
// reference computed with division and modulo, independent of double-dabble.
module tb_sm_bin_to_bcd;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] bin;
    logic        busy;
    logic        done;
    logic [31:0] bcd;
    logic [7:0]  digit_on;
    logic        overflow;

    int compareCount  = 0;
    int mismatchCount = 0;

    sm_bin_to_bcd dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .digit_on (digit_on),
        .overflow (overflow)
    );

    // Free-running 10-time-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: decimal digits by repeated division; all nines when too big.
    function automatic logic [31:0] refBcd(input logic [31:0] v);
        logic [31:0] r;
        longint unsigned x;
        r = 32'h0;
        if (v > 32'd99_999_999) return 32'h9999_9999;
        x = longint'(v);
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference: digit k is lit when the value reaches 10^k; digit 0 always.
    function automatic logic [7:0] refDigitOn(input logic [31:0] v);
        logic [7:0] m;
        longint unsigned p;
        if (v > 32'd99_999_999) return 8'hFF;
        m = 8'h00;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            m[i] = (longint'(v) >= p) || (i == 0);
            p = p * 10;
        end
        return m;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            mismatchCount++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input logic [31:0] v);
        checkValue("bcd", bcd, refBcd(v));
        checkValue("digit_on", {24'h0, digit_on}, {24'h0, refDigitOn(v)});
        checkValue("overflow", {31'h0, overflow}, {31'h0, v > 32'd99_999_999});
    endtask

    task automatic checkResetState();
        checkValue("rst_busy", {31'h0, busy}, 32'h0);
        checkValue("rst_done", {31'h0, done}, 32'h0);
        checkValue("rst_bcd", bcd, 32'h0);
        checkValue("rst_digit_on", {24'h0, digit_on}, 32'h01);
        checkValue("rst_overflow", {31'h0, overflow}, 32'h0);
    endtask

    // Runs one full conversion starting just after a clock edge, checking the
    // busy window, the done latency and pulse width, and the result.
    task automatic applyStimulus(input logic [31:0] v);
        logic busyOk;
        logic doneOk;
        start = 1'b1;
        bin   = v;
        @(posedge clock); #1;
        start = 1'b0;
        bin   = $urandom;
        checkValue("busy_after_accept", {31'h0, busy}, 32'h1);
        busyOk = 1'b1;
        doneOk = 1'b1;
        for (int n = 1; n < 27; n++) begin
            @(posedge clock); #1;
            if (busy !== 1'b1) busyOk = 1'b0;
            if (done !== 1'b0) doneOk = 1'b0;
        end
        checkValue("busy_window", {31'h0, busyOk}, 32'h1);
        checkValue("no_early_done", {31'h0, doneOk}, 32'h1);
        @(posedge clock); #1;
        checkValue("done_at_E27", {31'h0, done}, 32'h1);
        checkValue("busy_clear_E27", {31'h0, busy}, 32'h0);
        checkOutput(v);
        @(posedge clock); #1;
        checkValue("done_single_pulse", {31'h0, done}, 32'h0);
        checkOutput(v);
    endtask

    initial begin
        logic [31:0] v;
        logic        sawDone;
        reset = 1'b0;
        start = 1'b0;
        bin   = 32'h0;
        #2 reset = 1'b1;
        #1;
        checkResetState();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;

        applyStimulus(32'd0);
        applyStimulus(32'd12_345_678);
        applyStimulus(32'd305);
        applyStimulus(32'd99_999_999);
        applyStimulus(32'd100_000_000);
        applyStimulus(32'hFFFF_FFFF);

        // Starts during the conversion (E5 and E27) must be ignored; a start
        // still held at E28 begins a new conversion.
        start = 1'b1;
        bin   = 32'd42;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        start = 1'b1;
        bin   = 32'd7;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (21) @(posedge clock);
        #1;
        start = 1'b1;
        bin   = 32'd7;
        @(posedge clock); #1;
        checkValue("ignore_done_E27", {31'h0, done}, 32'h1);
        checkValue("ignore_bcd", bcd, 32'h0000_0042);
        checkValue("ignore_digit_on", {24'h0, digit_on}, 32'h03);
        @(posedge clock); #1;
        checkValue("accept_E28_busy", {31'h0, busy}, 32'h1);
        checkValue("accept_E28_done", {31'h0, done}, 32'h0);
        start = 1'b0;
        repeat (27) @(posedge clock);
        #1;
        checkValue("second_done", {31'h0, done}, 32'h1);
        checkOutput(32'd7);
        @(posedge clock); #1;

        // Reset in the middle of a conversion aborts it without a done pulse.
        applyStimulus(32'd42);
        start = 1'b1;
        bin   = 32'd9_876;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        @(posedge clock);
        reset = 1'b1;
        #1;
        checkResetState();
        @(negedge clock);
        @(negedge clock);
        reset   = 1'b0;
        sawDone = 1'b0;
        for (int n = 0; n < 35; n++) begin
            @(posedge clock); #1;
            if (done !== 1'b0 || busy !== 1'b0) sawDone = 1'b1;
        end
        checkValue("no_done_after_reset", {31'h0, sawDone}, 32'h0);
        applyStimulus(32'd9_876);

        // Random values with varied digit counts.
        for (int i = 0; i < 1000; i++) begin
            v = $urandom_range(99_999_999, 0) >> $urandom_range(26, 0);
            applyStimulus(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
